// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: instruction word type, loader state encoding
// and the instruction-memory address width helper.
package rv32_pkg;

  // Default instruction memory depth in 32-bit words.
  localparam int IMEM_DEPTH_DEF = 1024;

  // One RV32 instruction word.
  typedef logic [31:0] rv32_instr_t;

  // Program loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } ldr_state_t;

  // Word-address width for an imem of the given depth (at least one bit).
  function automatic int imem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IMEM_AW = imem_aw(IMEM_DEPTH_DEF);

endpackage

// File: rtl/pito_prog_loader.sv
// Streams a program into the pito core instruction memory, then holds the
// core in reset for a few cycles and releases it to run the new image.
module pito_prog_loader
  import rv32_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int RST_HOLD   = 4
) (
  input  logic                          rv32_io_clk,
  input  logic                          rv32_io_rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [imem_aw(IMEM_DEPTH):0]  prog_len,
  input  logic                          s_valid,
  input  rv32_instr_t                   s_data,
  output logic                          s_ready,
  output logic                          imem_w_en,
  output logic [imem_aw(IMEM_DEPTH)-1:0] imem_addr,
  output rv32_instr_t                   imem_data,
  output logic                          pito_program,
  output logic                          core_rst_n,
  output logic                          done,
  output logic                          len_err
);

  localparam int AW = imem_aw(IMEM_DEPTH);
  // Length / accept counter is one bit wider so a full-depth load is
  // counted without the address ever wrapping.
  localparam int LW = AW + 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  ldr_state_t      state, state_d;
  logic [LW-1:0]   cnt, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            len_err_d;
  logic            accept;
  logic            start_ok;

  // Next-state, counter and status decode for the load sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state;
    cnt_d     = cnt;
    len_d     = len_q;
    hold_d    = hold_cnt;
    len_err_d = len_err;

    s_ready      = (state == ST_LOAD);
    pito_program = (state == ST_LOAD) || (state == ST_DRAIN);
    core_rst_n   = (state == ST_RUN);
    done         = (state == ST_RUN);

    // An abort in the same cycle as a handshake drops the word.
    accept   = s_valid && s_ready && !abort;
    start_ok = (prog_len != '0) && (prog_len <= LW'(IMEM_DEPTH));

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            if (start_ok) begin
              state_d   = ST_LOAD;
              cnt_d     = '0;
              len_d     = prog_len;
              len_err_d = 1'b0;
            end else begin
              len_err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt_d = cnt + LW'(1);
            if (cnt == len_q - LW'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (RST_HOLD == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HW'(RST_HOLD - 1);
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state_d = ST_RUN;
          else                hold_d  = hold_cnt - HW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, counters and sticky length error.
  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      hold_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state    <= state_d;
      cnt      <= cnt_d;
      len_q    <= len_d;
      hold_cnt <= hold_d;
      len_err  <= len_err_d;
    end
  end

  // Registered imem write port: an accepted word is written one cycle later.
  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      imem_w_en <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      imem_w_en <= accept;
      if (accept) begin
        imem_addr <= cnt[AW-1:0];
        imem_data <= s_data;
      end
    end
  end

endmodule

// File: doc/pito_prog_loader.md
PITO_PROG_LOADER -- requirements
Module: pito_prog_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RST_HOLD, default 4, meaning cycles the core is held in reset after the last write.
REQ-003 SHALL have port rv32_io_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rv32_io_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin loading.
REQ-006 SHALL have port abort  in  1  one-cycle request to cancel and return to IDLE.
REQ-007 SHALL have port prog_len  in  $clog2(IMEM_DEPTH)+1  word count, sampled on accepted start.
REQ-008 SHALL have port s_valid  in  1  instruction word valid.
REQ-009 SHALL have port s_data  in  32  instruction word (rv32_instr_t).
REQ-010 SHALL have port s_ready  out  1  loader accepts s_data this cycle.
REQ-011 SHALL have port imem_w_en  out  1  core imem write enable.
REQ-012 SHALL have port imem_addr  out  $clog2(IMEM_DEPTH)  word address of write.
REQ-013 SHALL have port imem_data  out  32  word written.
REQ-014 SHALL have port pito_program  out  1  core program-mode flag.
REQ-015 SHALL have port core_rst_n  out  1  active-low reset driven to the core.
REQ-016 SHALL have port done  out  1  high while core runs the loaded program.
REQ-017 SHALL have port len_err  out  1  sticky; bad prog_len seen at start.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, HOLD, RUN.
REQ-019 IDLE: core_rst_n=0, pito_program=0, s_ready=0; start with 1<=prog_len<=IMEM_DEPTH -> LOAD, counter cleared, len_err cleared.
REQ-020 IDLE: start with prog_len=0 or >IMEM_DEPTH -> stay IDLE, len_err=1.
REQ-021 LOAD: s_ready=1, pito_program=1, core_rst_n=0.
REQ-022 Handshake: word accepted when s_valid&&s_ready; s_valid without s_ready leaves data pending, no loss.
REQ-023 Accepted word i SHALL appear on the next cycle as imem_w_en=1, imem_addr=i, imem_data=s_data (1-cycle latency, registered).
REQ-024 imem_w_en SHALL be 0 in every cycle without a preceding accept.
REQ-025 Accept counter SHALL increment by 1 per accept; accept of word prog_len-1 -> DRAIN, s_ready=0 in that next cycle.
REQ-026 DRAIN: one cycle, last write issued; -> HOLD with hold counter = RST_HOLD-1.
REQ-027 HOLD: pito_program=0, core_rst_n=0, counter decrements; at 0 -> RUN.
REQ-028 RUN: core_rst_n=1, done=1, pito_program=0; start with valid prog_len -> LOAD (core re-reset next cycle).
REQ-029 abort in any state SHALL force IDLE next cycle; abort has priority over start and over a same-cycle accept (word dropped, no write).
REQ-030 start outside IDLE/RUN SHALL be ignored.
REQ-031 Address SHALL never wrap: prog_len=IMEM_DEPTH writes addresses 0..IMEM_DEPTH-1 exactly.

Reset
REQ-032 Reset assertion SHALL force IDLE asynchronously, mid-operation included.
REQ-033 Reset values: s_ready=0, imem_w_en=0, imem_addr=0, imem_data=0, pito_program=0, core_rst_n=0, done=0, len_err=0, counters=0.

Structure
REQ-034 State enum, rv32_instr_t and IMEM address width SHALL live in the shared rv32 package.
REQ-035 Single module; no sub-modules; hold counter and accept counter inline.

Verification
REQ-036 Load 3 words 0x000000B7,0x00100113,0x00208193 with s_valid held high -> writes at addr 0,1,2 on consecutive cycles, core_rst_n rises 1+RST_HOLD cycles after last write, done=1.
REQ-037 Load 4 words with s_valid toggling every other cycle -> exactly 4 writes, addresses 0..3 in order, no duplicates.
REQ-038 start with prog_len=0, then prog_len=IMEM_DEPTH+1 -> state stays IDLE, len_err=1, no writes.
REQ-039 abort coincident with accept of word 2 of 5 -> no write for word 2, IDLE next cycle, core_rst_n=0.
REQ-040 rv32_io_rst_n asserted during HOLD -> all outputs at reset values same cycle; later start reloads from addr 0.
REQ-041 prog_len=IMEM_DEPTH -> last write at IMEM_DEPTH-1, no address wrap, RUN reached.
